// File: rtl/fb_pkg.sv
// Shared constants, types, FSM state encoding and reference requantizer
// for the filterbank channel serializer.
package fb_pkg;

  localparam int unsigned FB_NCH   = 16;
  localparam int unsigned FB_IN_W  = 23;
  localparam int unsigned FB_OUT_W = 16;
  localparam int unsigned FB_SHIFT = 7;
  localparam int unsigned FB_EXT_W = FB_IN_W + 1;

  typedef logic signed [FB_IN_W-1:0] fb_sample_t;
  typedef fb_sample_t fb_frame_t [FB_NCH];

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } fb_state_t;

  // Round half up by 2^shift, then saturate to the output range.
  function automatic logic signed [FB_OUT_W-1:0] fb_requantize(input fb_sample_t x,
                                                              input int unsigned shift);
    logic signed [FB_EXT_W-1:0] t;
    logic signed [FB_EXT_W-1:0] maxv;
    logic signed [FB_EXT_W-1:0] minv;
    maxv = FB_EXT_W'((64'd1 << (FB_OUT_W - 1)) - 64'd1);
    minv = ~maxv;
    t    = {x[FB_IN_W-1], x};
    if (shift > 0) begin
      t = (t + $signed(FB_EXT_W'(1) << (shift - 1))) >>> shift;
    end
    if (t > maxv) begin
      return maxv[FB_OUT_W-1:0];
    end else if (t < minv) begin
      return minv[FB_OUT_W-1:0];
    end
    return t[FB_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/fb_requant.sv
// Combinational round-half-up shift plus saturation of one channel sample.
module fb_requant #(
  parameter int unsigned IN_W  = 23,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 7
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y_c
);

  localparam int unsigned EW = IN_W + 1;
  localparam int unsigned RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [EW-1:0] RND  = (SHIFT > 0) ? (EW'(1) << RS) : '0;
  localparam logic signed [EW-1:0] MAXV = EW'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] r;

  // Extend by one bit so the rounding add cannot overflow, then clamp.
  always_comb begin
    ext = {x[IN_W-1], x};
    r   = (ext + RND) >>> SHIFT;
    if (r > MAXV) begin
      y_c = MAXV[OUT_W-1:0];
    end else if (r < MINV) begin
      y_c = MINV[OUT_W-1:0];
    end else begin
      y_c = r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fb_channel_serializer.sv
// Ping-pong frame buffer that serializes filterbank channel outputs onto a
// valid/ready stream. Optional per-frame channel mask: FB_CHAN_MASK_EN.
module fb_channel_serializer
  import fb_pkg::*;
#(
  parameter int unsigned NCH   = FB_NCH,
  parameter int unsigned IN_W  = FB_IN_W,
  parameter int unsigned OUT_W = FB_OUT_W,
  parameter int unsigned SHIFT = FB_SHIFT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     frame_valid,
  input  logic signed [IN_W-1:0]   ch_in [NCH],
`ifdef FB_CHAN_MASK_EN
  input  logic [NCH-1:0]           chan_mask,
`endif
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [$clog2(NCH)-1:0]   out_chan,
  output logic                     out_last,
  output logic                     overrun,
  output logic [15:0]              frame_cnt
);

  localparam int unsigned CW  = $clog2(NCH);
  localparam int unsigned CW1 = CW + 1;

  // Lowest enabled channel at or above start; MSB flags that one exists.
  function automatic logic [CW:0] next_en(input logic [NCH-1:0] m, input logic [CW:0] start);
    logic [CW:0] res;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (CW1'(i) >= start)) begin
        res = {1'b1, CW'(i)};
      end
    end
    return res;
  endfunction

  fb_state_t             state, state_nxt;
  logic signed [IN_W-1:0] bank_mem [2][NCH];
  logic [1:0]            bank_full;
  logic                  wr_bank, rd_bank;

  logic [NCH-1:0]        rd_mask, oth_mask, sel_mask;
  logic [CW:0]           first_rd, first_oth, succ, after_sel;
  logic                  hs, rel, load, valid_nxt, sel_bank, sel_last;
  logic [CW-1:0]         sel_chan;
  logic                  cap_en, wr_free;
  logic signed [OUT_W-1:0] rq_data;

`ifdef FB_CHAN_MASK_EN
  logic [NCH-1:0] bank_mask [2];
  assign rd_mask  = bank_mask[rd_bank];
  assign oth_mask = bank_mask[~rd_bank];
  assign sel_mask = bank_mask[sel_bank];
`else
  assign rd_mask  = '1;
  assign oth_mask = '1;
  assign sel_mask = '1;
`endif

  assign hs      = out_valid && out_ready && clk_enable;
  assign cap_en  = frame_valid && clk_enable;
  assign wr_free = !bank_full[wr_bank] || (rel && (rd_bank == wr_bank));

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain sequencing: choose which bank/channel feeds the output register next.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rel       = 1'b0;
    valid_nxt = out_valid;
    sel_bank  = rd_bank;
    sel_chan  = '0;
    first_rd  = next_en(rd_mask, '0);
    first_oth = next_en(oth_mask, '0);
    succ      = next_en(rd_mask, {1'b0, out_chan} + CW1'(1));
    if (clk_enable) begin
      case (state)
        IDLE: begin
          if (bank_full[rd_bank]) begin
            if (first_rd[CW]) begin
              load      = 1'b1;
              sel_chan  = first_rd[CW-1:0];
              valid_nxt = 1'b1;
              state_nxt = DRAIN;
            end else begin
              rel = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (hs) begin
            if (!out_last) begin
              load     = 1'b1;
              sel_chan = succ[CW-1:0];
            end else begin
              rel = 1'b1;
              if (bank_full[~rd_bank] && first_oth[CW]) begin
                load     = 1'b1;
                sel_bank = ~rd_bank;
                sel_chan = first_oth[CW-1:0];
              end else begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    after_sel = next_en(sel_mask, {1'b0, sel_chan} + CW1'(1));
    sel_last  = !after_sel[CW];
  end

  fb_requant #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_requant (
    .x  (bank_mem[sel_bank][sel_chan]),
    .y_c(rq_data)
  );

  // Frame storage; contents only matter while the bank is flagged full.
  always_ff @(posedge clock) begin
    if (cap_en && wr_free) begin
      for (int i = 0; i < NCH; i++) begin
        bank_mem[wr_bank][i] <= ch_in[i];
      end
`ifdef FB_CHAN_MASK_EN
      bank_mask[wr_bank] <= chan_mask;
`endif
    end
  end

  // Bank bookkeeping, capture accounting and output register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      out_valid <= valid_nxt;
      if (load) begin
        out_data <= rq_data;
        out_chan <= sel_chan;
        out_last <= sel_last;
      end
      if (rel) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
      // Set after clear so a capture into the bank just released wins.
      if (cap_en) begin
        if (wr_free) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
          frame_cnt          <= frame_cnt + 16'd1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_channel_serializer.sv
// Randomized bench for fb_channel_serializer with a frame-queue reference model.
module tb_fb_channel_serializer;

  localparam int NCH = 16;

  logic                clock;
  logic                reset;
  logic                clk_enable;
  logic                frame_valid;
  logic signed [22:0]  ch_in [NCH];
  logic                out_ready;
  logic                out_valid;
  logic signed [15:0]  out_data;
  logic [3:0]          out_chan;
  logic                out_last;
  logic                overrun;
  logic [15:0]         frame_cnt;

  fb_channel_serializer dut (
    .clock      (clock),
    .reset      (reset),
    .clk_enable (clk_enable),
    .frame_valid(frame_valid),
    .ch_in      (ch_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_last   (out_last),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int data;
    int chan;
    int last;
  } beat_t;

  beat_t exp_q [$];
  int    stored;
  int    m_cnt;
  int    m_ovr;
  int    n_cmp;
  int    n_bad;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Round half up by 128 and clamp to 16-bit signed.
  function automatic int ref_rq(input int x);
    int v;
    v = (x + 64) >>> 7;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // One clock: observe the handshake and capture, update the model, check.
  task automatic tick();
    logic  hs, cap, rst_now;
    int    pd, pc, pl;
    beat_t e;
    rst_now = !reset;
    hs  = out_valid && out_ready && clk_enable && !rst_now;
    cap = frame_valid && clk_enable && !rst_now;
    pd  = out_data;
    pc  = out_chan;
    pl  = out_last;
    @(posedge clock);
    #1;
    if (rst_now) begin
      exp_q.delete();
      stored = 0;
      m_cnt  = 0;
      m_ovr  = 0;
    end else begin
      if (hs) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_data", pd, e.data);
          check_eq("beat_chan", pc, e.chan);
          check_eq("beat_last", pl, e.last);
          if (e.last != 0) stored--;
        end
      end
      if (cap) begin
        if (stored < 2) begin
          stored++;
          m_cnt = (m_cnt + 1) & 16'hFFFF;
          for (int i = 0; i < NCH; i++) begin
            e.data = ref_rq(int'(ch_in[i]));
            e.chan = i;
            e.last = (i == NCH - 1) ? 1 : 0;
            exp_q.push_back(e);
          end
        end else begin
          m_ovr = 1;
        end
      end
    end
    check_eq("frame_cnt", int'(frame_cnt), m_cnt);
    check_eq("overrun", int'(overrun), m_ovr);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NCH; i++) begin
      case ($urandom_range(0, 7))
        0:       ch_in[i] = 23'sh3FFFFF;
        1:       ch_in[i] = 23'sh400000;
        default: ch_in[i] = 23'($urandom);
      endcase
    end
  endtask

  task automatic pulse_frame();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, int'(out_valid), 0);
    check_eq({tag, "_data"}, int'(out_data), 0);
    check_eq({tag, "_chan"}, int'(out_chan), 0);
    check_eq({tag, "_last"}, int'(out_last), 0);
    check_eq({tag, "_overrun"}, int'(overrun), 0);
    check_eq({tag, "_cnt"}, int'(frame_cnt), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    check_zero_outputs("rst");
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; stored = 0; m_cnt = 0; m_ovr = 0;
    reset = 1'b0; clk_enable = 1'b1; frame_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) ch_in[i] = '0;
    tick();
    do_reset();

    // Single ramp frame: latency, 16 back-to-back beats, then idle.
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) ch_in[i] = 23'(i * 128);
    pulse_frame();
    check_eq("lat_capture_edge", int'(out_valid), 0);
    tick();
    check_eq("lat_first_valid", int'(out_valid), 1);
    check_eq("lat_first_chan", int'(out_chan), 0);
    check_eq("lat_first_data", int'(out_data), 0);
    for (int k = 0; k < NCH - 1; k++) begin
      tick();
      check_eq("stream_valid", int'(out_valid), 1);
    end
    tick();
    check_eq("stream_end_valid", int'(out_valid), 0);
    check_eq("stream_cnt", int'(frame_cnt), 1);

    // Rounding and saturation corners.
    rand_frame();
    ch_in[0] = 23'sd64;
    ch_in[1] = -23'sd65;
    ch_in[2] = 23'sd4194303;
    ch_in[3] = -23'sd4194304;
    pulse_frame();
    for (int k = 0; k < 20; k++) tick();

    // Backpressure with ready toggling every cycle.
    rand_frame();
    pulse_frame();
    for (int k = 0; k < 40; k++) begin
      out_ready = k[0];
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check_eq("bp_drained", exp_q.size(), 0);

    // Ping-pong fill with a stalled sink, third frame dropped.
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      pulse_frame();
      for (int k = 0; k < 3; k++) tick();
    end
    check_eq("pp_overrun", int'(overrun), 1);
    out_ready = 1'b1;
    for (int k = 0; k < 2 * NCH; k++) begin
      check_eq("pp_no_bubble", int'(out_valid), 1);
      tick();
    end
    check_eq("pp_end_valid", int'(out_valid), 0);

    // Capture coinciding with the final beat of a full ping-pong.
    do_reset();
    out_ready = 1'b0;
    rand_frame(); pulse_frame(); tick();
    rand_frame(); pulse_frame(); tick(); tick();
    out_ready = 1'b1;
    for (int k = 0; k < NCH - 1; k++) tick();
    check_eq("rel_chan", int'(out_chan), NCH - 1);
    rand_frame();
    pulse_frame();
    check_eq("rel_cnt", int'(frame_cnt), 3);
    check_eq("rel_overrun", int'(overrun), 0);
    for (int k = 0; k < 2 * NCH + 4; k++) tick();
    check_eq("rel_drained", exp_q.size(), 0);

    // Reset in the middle of a drain.
    rand_frame(); pulse_frame(); tick();
    for (int k = 0; k < 5; k++) tick();
    check_eq("mid_chan", int'(out_chan), 5);
    do_reset();
    tick();
    check_eq("post_rst_valid", int'(out_valid), 0);
    rand_frame(); pulse_frame(); tick();
    check_eq("post_rst_chan", int'(out_chan), 0);
    for (int k = 0; k < 20; k++) tick();

    // Random traffic, sink stalls and enable gaps.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        rand_frame();
        frame_valid = 1'b1;
      end else begin
        frame_valid = 1'b0;
      end
      out_ready  = ($urandom_range(0, 9) < 7);
      clk_enable = ($urandom_range(0, 9) != 0);
      tick();
    end
    frame_valid = 1'b0; out_ready = 1'b1; clk_enable = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    check_eq("final_queue", exp_q.size(), 0);
    check_eq("final_valid", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_channel_serializer.md
Name: fb_channel_serializer

Overview:
- Downstream of the 16-channel filterbank core: captures all 16 sfix23 channel outputs on each decimated output strobe (phase_46).
- Requantizes each channel and emits the channels one per beat on a valid/ready stream, channel 0 first.
- Uses a two-bank ping-pong buffer, so one frame is drained while the next is captured. Frames that cannot be stored are dropped and flagged.

Parameters:
- NCH, 16, number of channels per frame (power of 2).
- IN_W, 23, channel input width (signed).
- OUT_W, 16, output sample width (signed).
- SHIFT, 7, arithmetic right shift applied before saturation (0..IN_W-1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- clk_enable  in  1  global enable; when low, all state holds and no handshake completes
- frame_valid  in  1  one-cycle strobe; ch_in is valid this cycle (driven from phase_46)
- ch_in  in  IN_W x NCH  unpacked signed array, index = channel
- out_ready  in  1  sink ready
- out_valid  out  1  out_data/out_chan valid
- out_data  out  OUT_W  requantized sample
- out_chan  out  log2(NCH)  channel index of out_data
- out_last  out  1  high on channel NCH-1 beat
- overrun  out  1  sticky; set when a frame is dropped
- frame_cnt  out  16  count of accepted frames, wraps

Behaviour:
- Reset (reset==0 at posedge), regardless of clk_enable:
  - out_valid=0, out_data=0, out_chan=0, out_last=0, overrun=0, frame_cnt=0.
  - Both banks are marked empty, and wr_bank=rd_bank=0.
  - A drain in progress is abandoned; no beat is emitted after reset.
- Storage: 2 banks x NCH x IN_W, each bank with a full flag.
- Capture, on frame_valid && clk_enable:
  - If bank wr_bank is empty, or will be freed this cycle by the final handshake, latch ch_in into it.
  - Then set its full flag, toggle wr_bank and increment frame_cnt.
  - Otherwise drop the frame, set overrun and leave frame_cnt unchanged.
- Drain FSM has two states, IDLE and DRAIN:
  - IDLE -> DRAIN when bank rd_bank is full. Load out_data from channel 0, set out_chan=0 and assert out_valid on that same edge.
  - Latency: a frame captured at edge t, with the FSM idle and the bank empty, gives out_valid=1 after edge t+1.
  - In DRAIN, a handshake (out_valid && out_ready && clk_enable) advances out_chan and loads the next channel's requantized value.
  - out_data, out_chan and out_last hold stable while out_valid && !out_ready.
  - Handshake with out_last=1: clear the full flag of rd_bank and toggle rd_bank.
  - If the other bank is already full, go straight to its channel 0 with no bubble (out_valid stays 1). Otherwise drop out_valid and return to IDLE.
- Requantize (combinational, before the out_data register):
  - SHIFT>0: r = (x + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits (round half up).
  - SHIFT=0: r = x.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Simultaneous events:
  - Capture into the bank being released by the final beat in the same cycle is permitted. The new data is written; the read side sees the bank full again on the next edge.
  - Capture and drain of different banks in the same cycle are independent.
- overrun clears only on reset.

Optional Feature:
- Macro: FB_CHAN_MASK_EN.
- Defined:
  - Adds input chan_mask [NCH-1:0], sampled on the capture edge and stored per bank.
  - The drain emits only channels whose mask bit is 1, in ascending order; out_last marks the highest enabled channel.
  - An all-zero mask frame is accepted and counted, then released one cycle after it reaches rd_bank, with no beats emitted.
- Undefined: no port; all NCH channels are emitted every frame.

Decomposition:
- Package fb_pkg:
  - FB_NCH, FB_IN_W and FB_OUT_W constants.
  - typedef fb_sample_t (signed [FB_IN_W-1:0]) and fb_frame_t (fb_sample_t [FB_NCH]).
  - The requantize function.
- One sub-module, fb_requant: a parameterized combinational round+saturate, instanced once on the read path.

Test Plan:
- Reset, single frame: ch_in[i] = i*128, SHIFT=7, out_ready=1 -> 16 beats on consecutive cycles with out_data = 0,1,...,15. The first beat appears the cycle after capture; out_last on chan 15; frame_cnt=1.
- Rounding/saturation: ch_in[0]=64, ch_in[1]=-65, ch_in[2]=4194303, ch_in[3]=-4194304 -> out_data 1, -1, 32767, -32768.
- Backpressure: out_ready toggles 1/0 every cycle -> each beat held stable while stalled; 16 beats in 32 cycles; no data lost.
- Ping-pong/overrun: out_ready=0; three frame_valid pulses 4 cycles apart -> first two accepted (frame_cnt=2), third dropped with overrun=1. Releasing out_ready -> 32 beats back-to-back with no bubble at the bank switch.
- Same-cycle release: both banks full; frame_valid coincides with the out_last handshake -> frame accepted, frame_cnt increments, overrun stays 0.
- Mid-drain reset: reset=0 at beat 5 -> next cycle out_valid=0 and all outputs zero; a subsequent frame drains from chan 0.
